// File: rtl/vram_arbiter_pkg.sv
// ============================================================================
// vram_arbiter_pkg
// Shared widths, CPU FSM state encodings and read-tag encodings.
// Revision: 1.0
// ============================================================================
`default_nettype none

package vram_arbiter_pkg;

    localparam int VRAM_ADDR_W = 13;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_WR   = 2'd1,
        C_RD1  = 2'd2,
        C_RD2  = 2'd3
    } cpu_state_t;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_CPU  = 2'd2
    } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/vram_arbiter.sv
// ============================================================================
// vram_arbiter
// Single-port video RAM sharing: VGA fetch has priority, CPU takes free slots.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_vga_req,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic [DATA_W-1:0] o_vga_data,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_din,
    output logic [DATA_W-1:0] o_cpu_dout,
    output logic              o_cpu_ack,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    cpu_state_t        r_state;
    cpu_state_t        w_state_next;
    logic              w_ack_next;
    logic              w_cpu_issue;
    rd_tag_t           r_tag0;
    rd_tag_t           r_tag1;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_vga_data;
    logic [DATA_W-1:0] r_cpu_dout;
    logic              r_cpu_ack;

    // Blocking on r_cpu_ack keeps a still-held request from being re-issued.
    assign w_cpu_issue = !i_vga_req && i_cpu_req && (r_state == C_IDLE) && !r_cpu_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ack_next   = 1'b0;
        case (r_state)
            C_IDLE: begin
                if (w_cpu_issue) begin
                    w_state_next = i_cpu_we ? C_WR : C_RD1;
                end
            end
            C_WR: begin
                w_state_next = C_IDLE;
                w_ack_next   = 1'b1;
            end
            C_RD1: begin
                w_state_next = C_RD2;
            end
            C_RD2: begin
                w_state_next = C_IDLE;
                w_ack_next   = 1'b1;
            end
            default: begin
                w_state_next = C_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_tag0      <= TAG_NONE;
            r_tag1      <= TAG_NONE;
            r_vga_data  <= '0;
            r_cpu_dout  <= '0;
            r_cpu_ack   <= 1'b0;
        end else begin
            r_ram_en  <= i_vga_req || w_cpu_issue;
            r_ram_we  <= w_cpu_issue && i_cpu_we;
            r_cpu_ack <= w_ack_next;
            if (i_vga_req) begin
                r_ram_addr <= i_vga_addr;
            end else if (w_cpu_issue) begin
                r_ram_addr  <= i_cpu_addr;
                r_ram_wdata <= i_cpu_din;
            end
            // Tag travels alongside the access so returning data finds its owner.
            if (i_vga_req) begin
                r_tag0 <= TAG_VGA;
            end else if (w_cpu_issue && !i_cpu_we) begin
                r_tag0 <= TAG_CPU;
            end else begin
                r_tag0 <= TAG_NONE;
            end
            r_tag1 <= r_tag0;
            if (r_tag1 == TAG_VGA) begin
                r_vga_data <= i_ram_rdata;
            end else if (r_tag1 == TAG_CPU) begin
                r_cpu_dout <= i_ram_rdata;
            end
        end
    end

    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_vga_data  = r_vga_data;
    assign o_cpu_dout  = r_cpu_dout;
    assign o_cpu_ack   = r_cpu_ack;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// tb_vram_arbiter
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vga_req = 1'b0;
    logic [12:0] vga_addr = '0;
    logic [7:0]  vga_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        ram_en;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = '0;

    logic [7:0]  mem [0:8191];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_iss;
    int          n_ack;
    logic        ack_seen;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    vram_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_vga_req   (vga_req),
        .i_vga_addr  (vga_addr),
        .o_vga_data  (vga_data),
        .i_cpu_req   (cpu_req),
        .i_cpu_we    (cpu_we),
        .i_cpu_addr  (cpu_addr),
        .i_cpu_din   (cpu_din),
        .o_cpu_dout  (cpu_dout),
        .o_cpu_ack   (cpu_ack),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[13'h0123] = 8'h5A;
        mem[13'h0020] = 8'h77;
        mem[13'h0010] = 8'h3C;
        mem[13'h0100] = 8'hA0;
        mem[13'h0101] = 8'hA1;
        mem[13'h0102] = 8'hA2;
        mem[13'h0050] = 8'hEE;

        // Reset values
        tick(); tick();
        chk("rst_ram_en", 16'(ram_en), 16'h0);
        chk("rst_ram_we", 16'(ram_we), 16'h0);
        chk("rst_ram_addr", 16'(ram_addr), 16'h0);
        chk("rst_ram_wdata", 16'(ram_wdata), 16'h0);
        chk("rst_vga_data", 16'(vga_data), 16'h0);
        chk("rst_cpu_dout", 16'(cpu_dout), 16'h0);
        chk("rst_cpu_ack", 16'(cpu_ack), 16'h0);
        reset = 1'b0;
        tick(); tick();

        // VGA only: request in cycle t, data at t+3
        vga_req = 1'b1; vga_addr = 13'h0123;
        tick(); vga_req = 1'b0; vga_addr = 13'h1FFF;
        chk("vga_ram_en", 16'(ram_en), 16'h1);
        chk("vga_ram_we", 16'(ram_we), 16'h0);
        chk("vga_ram_addr", 16'(ram_addr), 16'h0123);
        tick();
        chk("vga_ram_we_t2", 16'(ram_we), 16'h0);
        chk("vga_data_t2", 16'(vga_data), 16'h00);
        tick();
        chk("vga_data_t3", 16'(vga_data), 16'h5A);
        chk("vga_ram_we_t3", 16'(ram_we), 16'h0);
        tick();

        // CPU write 0x0400 <= 0xC3; late din change must be ignored
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0400; cpu_din = 8'hC3;
        tick(); cpu_din = 8'hFF; cpu_addr = 13'h0011;
        chk("wr_ram_en", 16'(ram_en), 16'h1);
        chk("wr_ram_we", 16'(ram_we), 16'h1);
        chk("wr_ram_addr", 16'(ram_addr), 16'h0400);
        chk("wr_ram_wdata", 16'(ram_wdata), 16'h00C3);
        chk("wr_ack_t1", 16'(cpu_ack), 16'h0);
        tick();
        chk("wr_ack_t2", 16'(cpu_ack), 16'h1);
        cpu_req = 1'b0;
        tick();
        chk("wr_ack_t3", 16'(cpu_ack), 16'h0);
        chk("wr_mem", 16'(mem[13'h0400]), 16'h00C3);
        chk("wr_mem_11", 16'(mem[13'h0011]), 16'h0000);

        // CPU read 0x0400 with request held across ack
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0400;
        tick();
        chk("rd_ram_en", 16'(ram_en), 16'h1);
        chk("rd_ack_t1", 16'(cpu_ack), 16'h0);
        tick();
        chk("rd_ack_t2", 16'(cpu_ack), 16'h0);
        tick();
        chk("rd_ack_t3", 16'(cpu_ack), 16'h1);
        chk("rd_dout", 16'(cpu_dout), 16'h00C3);
        tick();
        chk("held_no_issue", 16'(ram_en), 16'h0);
        chk("held_ack_t4", 16'(cpu_ack), 16'h0);
        tick();
        chk("held_reissue", 16'(ram_en), 16'h1);
        cpu_req = 1'b0;
        tick(); tick();
        chk("held_ack2", 16'(cpu_ack), 16'h1);
        tick();
        chk("held_ack2_end", 16'(cpu_ack), 16'h0);
        chk("held_idle", 16'(ram_en), 16'h0);

        // Collision: VGA 0x20 and CPU read 0x10 in the same cycle
        vga_req = 1'b1; vga_addr = 13'h0020;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
        tick(); vga_req = 1'b0;
        chk("col_vga_first", 16'(ram_addr), 16'h0020);
        tick();
        chk("col_cpu_second", 16'(ram_addr), 16'h0010);
        tick();
        chk("col_vga_data", 16'(vga_data), 16'h0077);
        chk("col_ack_t3", 16'(cpu_ack), 16'h0);
        tick();
        chk("col_ack_t4", 16'(cpu_ack), 16'h1);
        chk("col_cpu_dout", 16'(cpu_dout), 16'h003C);
        cpu_req = 1'b0;
        tick(); tick();

        // Full line: VGA every 16 cycles, continuous CPU reads of 0x10
        n_iss = 0; n_ack = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
        for (int cyc = 0; cyc < 48; cyc++) begin
            if (ram_en && !ram_we && ram_addr == 13'h0010) n_iss++;
            if (cpu_ack) n_ack++;
            if (cyc % 16 == 3) chk("line_vga_data", 16'(vga_data), 16'(8'hA0 + cyc / 16));
            vga_req  = (cyc % 16 == 0);
            vga_addr = 13'(13'h0100 + cyc / 16);
            tick();
        end
        vga_req = 1'b0; cpu_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (ram_en && !ram_we && ram_addr == 13'h0010) n_iss++;
            if (cpu_ack) n_ack++;
            tick();
        end
        chk("line_ack_eq_issue", 16'(n_ack), 16'(n_iss));
        chk("line_cpu_progress", 16'(n_ack >= 9), 16'h1);

        // Async reset during C_RD1
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
        tick();
        chk("rstmid_ram_en_pre", 16'(ram_en), 16'h1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_ram_en", 16'(ram_en), 16'h0);
        cpu_req = 1'b0;
        tick(); reset = 1'b0;
        ack_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            ack_seen = ack_seen | cpu_ack;
        end
        chk("rstmid_no_ack", 16'(ack_seen), 16'h0);

        // Async reset with a registered write pending
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0050; cpu_din = 8'h11;
        tick();
        chk("rstwr_ram_we_pre", 16'(ram_we), 16'h1);
        #2 reset = 1'b1;
        #1;
        chk("rstwr_ram_we", 16'(ram_we), 16'h0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick(); reset = 1'b0;
        tick();
        chk("rstwr_mem_kept", 16'(mem[13'h0050]), 16'h00EE);

        // Normal operation after release
        vga_req = 1'b1; vga_addr = 13'h0123;
        tick(); vga_req = 1'b0;
        tick(); tick();
        chk("post_rst_vga", 16'(vga_data), 16'h005A);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
